// File: rtl/nco_phase_gen_if.sv
// Configuration and phase-stream bundle for nco_phase_gen.
// The master side offers configuration and consumes theta. The slave side is the generator.
interface nco_phase_gen_if #(
  parameter int D_WIDTH   = 32,
  parameter int CNT_WIDTH = 16
);
  logic                 cfg_valid;
  logic                 cfg_ready;
  logic [D_WIDTH-1:0]   cfg_fcw;
  logic [D_WIDTH-1:0]   cfg_offset;
  logic [CNT_WIDTH-1:0] cfg_count;
  logic [D_WIDTH-1:0]   theta;
  logic                 theta_valid;
  logic                 theta_ready;

  modport master (
    output cfg_valid, cfg_fcw, cfg_offset, cfg_count, theta_ready,
    input  cfg_ready, theta, theta_valid
  );

  modport slave (
    input  cfg_valid, cfg_fcw, cfg_offset, cfg_count, theta_ready,
    output cfg_ready, theta, theta_valid
  );
endinterface

// File: rtl/nco_phase_gen.sv
// NCO phase generator. It emits bursts of theta = acc + offset, where acc advances by fcw on every
// output handshake. A count of zero selects continuous output until abort.
module nco_phase_gen #(
  parameter int D_WIDTH   = 32,
  parameter int CNT_WIDTH = 16
) (
  input  logic           clk,
  input  logic           rst,
  nco_phase_gen_if.slave bus,
  input  logic           start,
  input  logic           abort,
  output logic           busy,
  output logic           done
);
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [CNT_WIDTH-1:0] CNT_ZERO = {CNT_WIDTH{1'b0}};
  localparam logic [CNT_WIDTH-1:0] CNT_ONE  = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [D_WIDTH-1:0]   D_ZERO   = {D_WIDTH{1'b0}};

  state_t               state_q, state_d;
  logic [D_WIDTH-1:0]   fcw_q, fcw_d, offset_q, offset_d;
  logic [D_WIDTH-1:0]   acc_q, acc_d, theta_q, theta_d;
  logic [CNT_WIDTH-1:0] count_q, count_d, rem_q, rem_d;
  logic                 theta_valid_q, theta_valid_d;
  logic                 busy_q, busy_d, done_q, done_d, cfg_ready_q, cfg_ready_d;
  logic                 cfg_hs_s, out_hs_s, finite_s, last_s, go_s;
  logic [D_WIDTH-1:0]   acc_next_s;

  assign cfg_hs_s   = bus.cfg_valid & cfg_ready_q;
  assign out_hs_s   = theta_valid_q & bus.theta_ready;
  assign finite_s   = (count_q != CNT_ZERO);
  assign last_s     = finite_s && (rem_q == CNT_ONE);
  assign go_s       = start & ~abort;
  assign acc_next_s = acc_q + fcw_q;

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (go_s) state_d = S_RUN;
        else      state_d = S_IDLE;
      end
      S_RUN: begin
        if (abort)                  state_d = S_IDLE;
        else if (out_hs_s && last_s) state_d = S_DONE;
        else                        state_d = S_RUN;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // A start that coincides with a cfg handshake must see the freshly offered offset/count.
  always_comb begin
    fcw_d         = fcw_q;
    offset_d      = offset_q;
    count_d       = count_q;
    acc_d         = acc_q;
    rem_d         = rem_q;
    theta_d       = theta_q;
    theta_valid_d = theta_valid_q;
    if (cfg_hs_s) begin
      fcw_d    = bus.cfg_fcw;
      offset_d = bus.cfg_offset;
      count_d  = bus.cfg_count;
    end else begin
      fcw_d    = fcw_q;
    end
    case (state_q)
      S_IDLE: begin
        theta_valid_d = 1'b0;
        if (go_s) begin
          acc_d         = D_ZERO;
          theta_d       = cfg_hs_s ? bus.cfg_offset : offset_q;
          rem_d         = cfg_hs_s ? bus.cfg_count : count_q;
          theta_valid_d = 1'b1;
        end else begin
          theta_valid_d = 1'b0;
        end
      end
      S_RUN: begin
        if (out_hs_s) begin
          acc_d = acc_next_s;
          if (finite_s) rem_d = rem_q - CNT_ONE;
          else          rem_d = rem_q;
        end else begin
          acc_d = acc_q;
        end
        if (abort || (out_hs_s && last_s)) begin
          theta_valid_d = 1'b0;
        end else if (out_hs_s) begin
          theta_d       = acc_next_s + offset_q;
          theta_valid_d = 1'b1;
        end else begin
          theta_valid_d = theta_valid_q;
        end
      end
      S_DONE:  theta_valid_d = 1'b0;
      default: theta_valid_d = 1'b0;
    endcase
  end

  always_comb begin
    busy_d      = (state_d == S_RUN);
    done_d      = (state_d == S_DONE);
    cfg_ready_d = (state_d == S_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_IDLE;
      fcw_q         <= D_ZERO;
      offset_q      <= D_ZERO;
      count_q       <= CNT_ZERO;
      acc_q         <= D_ZERO;
      rem_q         <= CNT_ZERO;
      theta_q       <= D_ZERO;
      theta_valid_q <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      cfg_ready_q   <= 1'b1;
    end else begin
      state_q       <= state_d;
      fcw_q         <= fcw_d;
      offset_q      <= offset_d;
      count_q       <= count_d;
      acc_q         <= acc_d;
      rem_q         <= rem_d;
      theta_q       <= theta_d;
      theta_valid_q <= theta_valid_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      cfg_ready_q   <= cfg_ready_d;
    end
  end

  assign bus.cfg_ready   = cfg_ready_q;
  assign bus.theta       = theta_q;
  assign bus.theta_valid = theta_valid_q;
  assign busy            = busy_q;
  assign done            = done_q;
endmodule

// File: tb/tb_nco_phase_gen.sv
// Scoreboard bench for nco_phase_gen. Expected phases are queued when a burst is launched
// and are popped on each theta handshake.
`timescale 1ns/1ps
module tb_nco_phase_gen;
  localparam int DW = 8;
  localparam int CW = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic abort = 1'b0;
  logic busy, done;
  int total = 0;
  int bad = 0;
  logic [DW-1:0] exp_q[$];

  nco_phase_gen_if #(.D_WIDTH(DW), .CNT_WIDTH(CW)) bus ();
  nco_phase_gen #(.D_WIDTH(DW), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst(rst), .bus(bus), .start(start), .abort(abort), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic push_exp(input logic [DW-1:0] fcw, input logic [DW-1:0] off, input int n);
    logic [DW-1:0] ph;
    ph = off;
    for (int i = 0; i < n; i++) begin
      exp_q.push_back(ph);
      ph = ph + fcw;
    end
  endtask

  task automatic drive_cfg(input logic [DW-1:0] fcw, input logic [DW-1:0] off,
                           input logic [CW-1:0] cnt, input logic with_start);
    @(negedge clk);
    bus.cfg_valid  = 1'b1;
    bus.cfg_fcw    = fcw;
    bus.cfg_offset = off;
    bus.cfg_count  = cnt;
    start          = with_start;
  endtask

  task automatic test_reset;
    rst = 1'b1; bus.cfg_valid = 1'b0; bus.theta_ready = 1'b0;
    bus.cfg_fcw = '0; bus.cfg_offset = '0; bus.cfg_count = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    total++; if (bus.theta_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b want=0", bus.theta_valid); end
    total++; if (bus.theta !== 8'h00) begin bad++; $display("FAIL reset_theta got=%h want=00", bus.theta); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b want=0", done); end
    total++; if (bus.cfg_ready !== 1'b1) begin bad++; $display("FAIL reset_cfg_ready got=%b want=1", bus.cfg_ready); end
  endtask

  task automatic test_basic_burst;
    int hs, last_k, done_k;
    logic [DW-1:0] e;
    hs = 0; last_k = -1; done_k = -1;
    exp_q.delete();
    drive_cfg(8'h40, 8'h10, 4'd5, 1'b0);
    @(negedge clk);
    bus.cfg_valid = 1'b0;
    push_exp(8'h40, 8'h10, 5);
    start = 1'b1;
    for (int k = 0; k < 20 && done_k < 0; k++) begin
      @(negedge clk);
      start = 1'b0; bus.theta_ready = 1'b1;
      if (k == 0) begin
        total++; if (bus.theta_valid !== 1'b1) begin bad++; $display("FAIL basic_latency got=%b want=1", bus.theta_valid); end
      end
      if (bus.theta_valid === 1'b1) begin
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL basic_busy got=%b want=1", busy); end
        total++;
        if (exp_q.size() == 0) begin bad++; $display("FAIL basic_extra got=%h want=none", bus.theta); end
        else begin
          e = exp_q.pop_front();
          if (bus.theta !== e) begin bad++; $display("FAIL basic_theta got=%h want=%h", bus.theta, e); end
        end
        hs++; last_k = k;
      end
      if (done === 1'b1) done_k = k;
    end
    total++; if (hs != 5 || last_k != 4) begin bad++; $display("FAIL basic_rate got=%0d/%0d want=5/4", hs, last_k); end
    total++; if (done_k != 5) begin bad++; $display("FAIL basic_done_cycle got=%0d want=5", done_k); end
    @(negedge clk);
    total++; if (done !== 1'b0) begin bad++; $display("FAIL basic_done_width got=%b want=0", done); end
    total++; if (bus.cfg_ready !== 1'b1) begin bad++; $display("FAIL basic_cfg_ready got=%b want=1", bus.cfg_ready); end
  endtask

  task automatic test_backpressure;
    int hs, last_k, done_k, held;
    logic [DW-1:0] e;
    hs = 0; last_k = -1; done_k = -1; held = 0;
    exp_q.delete();
    drive_cfg(8'h40, 8'h10, 4'd5, 1'b0);
    @(negedge clk);
    bus.cfg_valid = 1'b0;
    push_exp(8'h40, 8'h10, 5);
    start = 1'b1;
    for (int k = 0; k < 25 && done_k < 0; k++) begin
      @(negedge clk);
      start = 1'b0;
      bus.theta_ready = !(k >= 1 && k <= 3);
      if (bus.theta_valid === 1'b1 && bus.theta_ready === 1'b0) begin
        held++;
        total++; if (exp_q.size() == 0 || bus.theta !== exp_q[0]) begin bad++; $display("FAIL bp_hold got=%h want=50", bus.theta); end
      end
      if (bus.theta_valid === 1'b1 && bus.theta_ready === 1'b1) begin
        total++;
        if (exp_q.size() == 0) begin bad++; $display("FAIL bp_extra got=%h want=none", bus.theta); end
        else begin
          e = exp_q.pop_front();
          if (bus.theta !== e) begin bad++; $display("FAIL bp_theta got=%h want=%h", bus.theta, e); end
        end
        hs++; last_k = k;
      end
      if (done === 1'b1) done_k = k;
    end
    total++; if (held != 3) begin bad++; $display("FAIL bp_held_cycles got=%0d want=3", held); end
    total++; if (hs != 5 || done_k != last_k + 1) begin bad++; $display("FAIL bp_done got=%0d/%0d want=5/%0d", hs, done_k, last_k + 1); end
  endtask

  task automatic test_continuous_abort;
    int hs, saw_done;
    logic [DW-1:0] e;
    hs = 0; saw_done = 0;
    exp_q.delete();
    drive_cfg(8'h01, 8'hFE, 4'd0, 1'b0);
    @(negedge clk);
    bus.cfg_valid = 1'b0;
    push_exp(8'h01, 8'hFE, 6);
    start = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      start = 1'b0; bus.theta_ready = 1'b1;
      abort = (k == 5);
      if (done === 1'b1) saw_done++;
      if (bus.theta_valid === 1'b1) begin
        total++;
        if (exp_q.size() == 0) begin bad++; $display("FAIL cont_extra got=%h want=none", bus.theta); end
        else begin
          e = exp_q.pop_front();
          if (bus.theta !== e) begin bad++; $display("FAIL cont_theta got=%h want=%h", bus.theta, e); end
        end
        hs++;
      end
    end
    @(negedge clk);
    abort = 1'b0;
    total++; if (bus.theta_valid !== 1'b0) begin bad++; $display("FAIL abort_valid got=%b want=0", bus.theta_valid); end
    total++; if (busy !== 1'b0 || bus.cfg_ready !== 1'b1) begin bad++; $display("FAIL abort_idle got=%b/%b want=0/1", busy, bus.cfg_ready); end
    for (int k = 0; k < 3; k++) begin
      if (done === 1'b1) saw_done++;
      @(negedge clk);
    end
    total++; if (saw_done != 0) begin bad++; $display("FAIL abort_no_done got=%0d want=0", saw_done); end
    total++; if (hs != 6 || exp_q.size() != 0) begin bad++; $display("FAIL cont_count got=%0d want=6", hs); end
  endtask

  task automatic test_collisions;
    int hs, done_k, cfg_bad;
    logic [DW-1:0] e;
    @(negedge clk);
    start = 1'b1; abort = 1'b1;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    total++; if (busy !== 1'b0 || bus.theta_valid !== 1'b0) begin bad++; $display("FAIL abort_start got=%b/%b want=0/0", busy, bus.theta_valid); end
    for (int pass = 0; pass < 2; pass++) begin
      hs = 0; done_k = -1; cfg_bad = 0;
      exp_q.delete();
      if (pass == 0) drive_cfg(8'h20, 8'h00, 4'd3, 1'b1);
      else begin @(negedge clk); start = 1'b1; end
      push_exp(8'h20, 8'h00, 3);
      for (int k = 0; k < 15 && done_k < 0; k++) begin
        @(negedge clk);
        bus.theta_ready = 1'b1;
        bus.cfg_valid = (pass == 0) && (k <= 2);
        bus.cfg_fcw = 8'h77; bus.cfg_offset = 8'h33; bus.cfg_count = 4'd0;
        start = (k == 1 || k == 2);
        if (busy === 1'b1 && bus.cfg_ready !== 1'b0) cfg_bad++;
        if (bus.theta_valid === 1'b1) begin
          total++;
          if (exp_q.size() == 0) begin bad++; $display("FAIL coll_extra got=%h want=none", bus.theta); end
          else begin
            e = exp_q.pop_front();
            if (bus.theta !== e) begin bad++; $display("FAIL coll_theta got=%h want=%h", bus.theta, e); end
          end
          hs++;
        end
        if (done === 1'b1) done_k = k;
      end
      start = 1'b0; bus.cfg_valid = 1'b0;
      total++; if (cfg_bad != 0) begin bad++; $display("FAIL coll_cfg_ready got=%0d want=0", cfg_bad); end
      total++; if (hs != 3 || done_k != 3) begin bad++; $display("FAIL coll_done got=%0d/%0d want=3/3", hs, done_k); end
    end
  endtask

  task automatic test_async_reset;
    int hs, done_k, saw_done;
    logic [DW-1:0] e;
    exp_q.delete();
    saw_done = 0;
    drive_cfg(8'h40, 8'h10, 4'd5, 1'b1);
    push_exp(8'h40, 8'h10, 2);
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      start = 1'b0; bus.cfg_valid = 1'b0; bus.theta_ready = 1'b1;
      total++;
      if (exp_q.size() == 0 || bus.theta_valid !== 1'b1) begin bad++; $display("FAIL arst_pre got=%b want=1", bus.theta_valid); end
      else begin
        e = exp_q.pop_front();
        if (bus.theta !== e) begin bad++; $display("FAIL arst_pre_theta got=%h want=%h", bus.theta, e); end
      end
    end
    #2 rst = 1'b1;
    #1;
    total++; if (bus.theta_valid !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL arst_immediate got=%b/%b want=0/0", bus.theta_valid, busy); end
    total++; if (bus.theta !== 8'h00 || done !== 1'b0) begin bad++; $display("FAIL arst_theta got=%h/%b want=00/0", bus.theta, done); end
    #1 rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      if (done === 1'b1 || busy === 1'b1) saw_done++;
    end
    total++; if (saw_done != 0 || bus.cfg_ready !== 1'b1) begin bad++; $display("FAIL arst_idle got=%0d/%b want=0/1", saw_done, bus.cfg_ready); end
    hs = 0; done_k = -1;
    exp_q.delete();
    drive_cfg(8'h40, 8'h10, 4'd2, 1'b1);
    push_exp(8'h40, 8'h10, 2);
    for (int k = 0; k < 10 && done_k < 0; k++) begin
      @(negedge clk);
      start = 1'b0; bus.cfg_valid = 1'b0; bus.theta_ready = 1'b1;
      if (bus.theta_valid === 1'b1) begin
        total++;
        if (exp_q.size() == 0) begin bad++; $display("FAIL arst_extra got=%h want=none", bus.theta); end
        else begin
          e = exp_q.pop_front();
          if (bus.theta !== e) begin bad++; $display("FAIL arst_post_theta got=%h want=%h", bus.theta, e); end
        end
        hs++;
      end
      if (done === 1'b1) done_k = k;
    end
    total++; if (hs != 2 || done_k != 2) begin bad++; $display("FAIL arst_post_done got=%0d/%0d want=2/2", hs, done_k); end
  endtask

  initial begin
    test_reset();
    test_basic_burst();
    test_backpressure();
    test_continuous_abort();
    test_collisions();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
